// File: rtl/accel_pkg.sv
// accel_pkg: shared types and default parameters for the wheel-pulse
// acceleration detector (accel_detect and its interface).
// No ports. Build option used elsewhere: ACCEL_DETECT_DELTA_EN.
package accel_pkg;

    typedef enum logic [0:0] {
        FIRST = 1'b0,
        RUN   = 1'b1
    } accel_state_t;

    localparam int unsigned DEF_WINDOW_CYCLES = 1000;
    localparam int unsigned DEF_CNT_W         = 8;
    localparam int unsigned DEF_SPEED_LIMIT   = 50;
    localparam int unsigned DEF_ACCEL_DELTA   = 4;

endpackage

// File: rtl/accel_detect_if.sv
// accel_detect_if: signal bundle between the measurement block and its user.
//   enable        master->slave  measurement enable
//   wheel_pulse   master->slave  raw wheel sensor level
//   accel_out     slave->master  one-cycle strobe toward the speed checker
//   sample_valid  slave->master  one-cycle strobe, sample_count just updated
//   sample_count  slave->master  pulse count of the last completed window
interface accel_detect_if
    import accel_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
);
    logic             enable;
    logic             wheel_pulse;
    logic             accel_out;
    logic             sample_valid;
    logic [CNT_W-1:0] sample_count;

    modport master (
        output enable,
        output wheel_pulse,
        input  accel_out,
        input  sample_valid,
        input  sample_count
    );

    modport slave (
        input  enable,
        input  wheel_pulse,
        output accel_out,
        output sample_valid,
        output sample_count
    );
endinterface

// File: rtl/accel_detect_pulse_sync.sv
// pulse_sync: two-flop synchronizer for an asynchronous level followed by a
// registered rising-edge detector.
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset
//   d        in   asynchronous input level
//   rise     out  one-cycle pulse, earliest 3 clk after the raw rise
module pulse_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);
    logic sync1;
    logic sync2;
    logic sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_q <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync1   <= d;
            sync2   <= sync1;
            sync2_q <= sync2;
            rise    <= sync2 & ~sync2_q;
        end
    end
endmodule

// File: rtl/accel_detect.sv
// accel_detect: counts synchronized wheel-sensor rising edges over a fixed
// window of WINDOW_CYCLES clocks, publishes the count and raises a one-cycle
// accel_out strobe when the window shows over-speed (count > SPEED_LIMIT).
// With ACCEL_DETECT_DELTA_EN defined, accel_out is also raised when a window
// exceeds the previous one by at least ACCEL_DELTA (never on the first window
// after reset or disable).
//   clk      in   clock, all logic on posedge
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of accel_detect_if (enable, wheel_pulse in;
//            accel_out, sample_valid, sample_count out)
//
// state | meaning
// FIRST | no reference window yet; delta check suppressed
// RUN   | previous window captured; delta check active
module accel_detect
    import accel_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned SPEED_LIMIT   = DEF_SPEED_LIMIT,
    parameter int unsigned ACCEL_DELTA   = DEF_ACCEL_DELTA
) (
    input  logic           clk,
    input  logic           reset_n,
    accel_detect_if.slave  bus
);
    localparam int unsigned      WIN_W    = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [31:0]      LIMIT_U  = 32'(SPEED_LIMIT);
    localparam logic [0:0]       ST_FIRST = FIRST;
    localparam logic [0:0]       ST_RUN   = RUN;

    logic             rise;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] pulse_cnt;
    logic [CNT_W-1:0] pulse_next;
    logic [CNT_W-1:0] sample_q;
    logic             valid_q;
    logic             accel_q;
    logic [0:0]       state;
    logic             win_end;
    logic             over_hit;
    logic             delta_ok;
    logic             delta_hit;

    pulse_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (bus.wheel_pulse),
        .rise    (rise)
    );

    assign win_end = (win_cnt == WIN_LAST);

    // Includes an edge arriving on the win_end cycle itself; saturates.
    assign pulse_next = (rise && (pulse_cnt != CNT_MAX)) ? pulse_cnt + CNT_W'(1) : pulse_cnt;

    // Compared at 32 bits so a limit wider than the counter simply never trips.
    assign over_hit = (32'(pulse_next) > LIMIT_U);

`ifdef ACCEL_DETECT_DELTA_EN
    logic [CNT_W-1:0] prev;
    logic [CNT_W:0]   prev_plus;

    // One extra bit so prev + delta cannot wrap around.
    assign prev_plus = {1'b0, prev} + (CNT_W+1)'(ACCEL_DELTA);
    assign delta_ok  = ({1'b0, pulse_next} >= prev_plus);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else if (!bus.enable) begin
            prev <= '0;
        end else if (win_end) begin
            prev <= pulse_next;
        end
    end
`else
    assign delta_ok = 1'b0;
`endif

    assign delta_hit = (state == ST_RUN) && delta_ok;

    // enable low takes priority over win_end: the closing window is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt   <= '0;
            pulse_cnt <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            accel_q   <= 1'b0;
            state     <= ST_FIRST;
        end else if (!bus.enable) begin
            win_cnt   <= '0;
            pulse_cnt <= '0;
            valid_q   <= 1'b0;
            accel_q   <= 1'b0;
            state     <= ST_FIRST;
        end else begin
            valid_q <= win_end;
            accel_q <= win_end && (over_hit || delta_hit);
            if (win_end) begin
                win_cnt   <= '0;
                pulse_cnt <= '0;
                sample_q  <= pulse_next;
                state     <= ST_RUN;
            end else begin
                win_cnt   <= win_cnt + WIN_W'(1);
                pulse_cnt <= pulse_next;
            end
        end
    end

    assign bus.sample_count = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.accel_out    = accel_q;
endmodule
